// File: rtl/i2cmb_seq_pkg.sv
// Shared constants and types for the iicmb_m_wb command sequencer.
package i2cmb_seq_pkg;

    // iicmb_m_wb register map
    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    // CSR value that enables the core and its interrupt output
    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    // CMDR opcodes
    localparam logic [7:0] CMD_READ_ACK = 8'h01;
    localparam logic [7:0] CMD_READ_NAK = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_START    = 8'h04;
    localparam logic [7:0] CMD_STOP     = 8'h05;
    localparam logic [7:0] CMD_SET_BUS  = 8'h06;

    // CMDR completion flags, highest priority first
    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    typedef enum logic [1:0] {
        STAT_OK  = 2'b00,
        STAT_NAK = 2'b01,
        STAT_AL  = 2'b10,
        STAT_ERR = 2'b11
    } status_t;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_BUS_DPR,
        S_BUS_CMD,
        S_START_CMD,
        S_ADDR_DPR,
        S_ADDR_CMD,
        S_WR_FETCH,
        S_WR_DPR,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_DPR,
        S_STOP_CMD,
        S_WAIT,
        S_IRQ_READ,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/i2cmb_wb_access.sv
// Single Wishbone master access. A go while idle launches one cycle;
// cyc/stb and the address/data/we are held until ack. done is combinational
// on the ack cycle and rdata is dat_i passed through, so the caller samples
// it on that same edge. busy stays high through the ack cycle, which
// guarantees at least one idle cycle before the next access can start.
module i2cmb_wb_access #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] dat,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack
);

    logic                  active_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;

    // Launch on go, hold the bus cycle until the slave acknowledges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
        end else if (!active_q) begin
            if (go) begin
                active_q <= 1'b1;
                we_q     <= we;
                adr_q    <= adr;
                dat_q    <= dat;
            end
        end else if (wb_ack) begin
            active_q <= 1'b0;
            we_q     <= 1'b0;
        end
    end

    assign busy     = active_q;
    assign done     = active_q & wb_ack;
    assign rdata    = wb_dat_i;
    assign wb_cyc   = active_q;
    assign wb_stb   = active_q;
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_dat_o = dat_q;

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// Turns one I2C transaction request into the iicmb_m_wb register sequence
// and reports read bytes plus a completion status.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_INIT      | write CSR=0xC0 once after reset
// S_IDLE      | ready for a request
// S_BUS_DPR   | DPR <= bus index
// S_BUS_CMD   | CMDR <= SET_BUS
// S_START_CMD | CMDR <= START
// S_ADDR_DPR  | DPR <= {addr, rw}
// S_ADDR_CMD  | CMDR <= WRITE (address byte)
// S_WR_FETCH  | wait for the next upstream write byte
// S_WR_DPR    | DPR <= write byte
// S_WR_CMD    | CMDR <= WRITE (data byte)
// S_RD_CMD    | CMDR <= READ_ACK, or READ_NAK on the last byte
// S_RD_DPR    | read DPR, emit rd_valid_o
// S_STOP_CMD  | CMDR <= STOP
// S_WAIT      | wait for irq_i
// S_IRQ_READ  | read CMDR (clears irq) and decode the outcome
// S_DONE      | pulse done_o
module i2cmb_wb_sequencer
    import i2cmb_seq_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_rw_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic [7:0]                wr_data_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [7:0]                rd_data_o,
    output logic                      rd_valid_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    seq_state_t state_q, state_d;
    seq_state_t cmd_q;
    seq_state_t after_don;

    logic [3:0]                bus_q;
    logic [I2C_ADDR_WIDTH-1:0] addr_q;
    logic                      rw_q;
    logic [LEN_WIDTH-1:0]      cnt_q;
    logic [7:0]                wr_byte_q;
    logic [7:0]                rd_data_q;
    logic                      rd_valid_q;
    status_t                   status_q;

    logic                     acc_go;
    logic                     acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [WB_DATA_WIDTH-1:0] acc_dat;
    logic                     acc_busy;
    logic                     acc_done;
    logic [WB_DATA_WIDTH-1:0] acc_rdata;

    logic cnt_last;
    logic cnt_zero;

    assign cnt_last = (cnt_q == LEN_WIDTH'(1));
    assign cnt_zero = (cnt_q == '0);

    i2cmb_wb_access #(
        .ADDR_WIDTH (WB_ADDR_WIDTH),
        .DATA_WIDTH (WB_DATA_WIDTH)
    ) u_access (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .go       (acc_go),
        .we       (acc_we),
        .adr      (acc_adr),
        .dat      (acc_dat),
        .busy     (acc_busy),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .wb_cyc   (cyc_o),
        .wb_stb   (stb_o),
        .wb_we    (we_o),
        .wb_adr   (adr_o),
        .wb_dat_o (dat_o),
        .wb_dat_i (dat_i),
        .wb_ack   (ack_i)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Where a successful (DON) completion leads, given the command just waited on
    always_comb begin
        after_don = S_DONE;
        unique case (cmd_q)
            S_BUS_CMD:   after_don = S_START_CMD;
            S_START_CMD: after_don = S_ADDR_DPR;
            S_ADDR_CMD: begin
                if (cnt_zero) begin
                    after_don = S_STOP_CMD;
                end else if (rw_q) begin
                    after_don = S_RD_CMD;
                end else begin
                    after_don = S_WR_FETCH;
                end
            end
            S_WR_CMD:    after_don = cnt_last ? S_STOP_CMD : S_WR_FETCH;
            S_RD_CMD:    after_don = S_RD_DPR;
            default:     after_don = S_DONE;
        endcase
    end

    // Next state and the access each state issues; every access state
    // launches once when the primitive is free and advances on its done
    always_comb begin
        state_d = state_q;
        acc_go  = 1'b0;
        acc_we  = 1'b1;
        acc_adr = WB_ADDR_WIDTH'(REG_CMDR);
        acc_dat = '0;
        unique case (state_q)
            S_INIT: begin
                acc_go  = !acc_busy;
                acc_adr = WB_ADDR_WIDTH'(REG_CSR);
                acc_dat = WB_DATA_WIDTH'(CSR_ENABLE);
                if (acc_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid_i) state_d = S_BUS_DPR;
            end
            S_BUS_DPR: begin
                acc_go  = !acc_busy;
                acc_adr = WB_ADDR_WIDTH'(REG_DPR);
                acc_dat = WB_DATA_WIDTH'(bus_q);
                if (acc_done) state_d = S_BUS_CMD;
            end
            S_BUS_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = WB_DATA_WIDTH'(CMD_SET_BUS);
                if (acc_done) state_d = S_WAIT;
            end
            S_START_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = WB_DATA_WIDTH'(CMD_START);
                if (acc_done) state_d = S_WAIT;
            end
            S_ADDR_DPR: begin
                acc_go  = !acc_busy;
                acc_adr = WB_ADDR_WIDTH'(REG_DPR);
                acc_dat = WB_DATA_WIDTH'({addr_q, rw_q});
                if (acc_done) state_d = S_ADDR_CMD;
            end
            S_ADDR_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = WB_DATA_WIDTH'(CMD_WRITE);
                if (acc_done) state_d = S_WAIT;
            end
            S_WR_FETCH: begin
                if (wr_valid_i) state_d = S_WR_DPR;
            end
            S_WR_DPR: begin
                acc_go  = !acc_busy;
                acc_adr = WB_ADDR_WIDTH'(REG_DPR);
                acc_dat = WB_DATA_WIDTH'(wr_byte_q);
                if (acc_done) state_d = S_WR_CMD;
            end
            S_WR_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = WB_DATA_WIDTH'(CMD_WRITE);
                if (acc_done) state_d = S_WAIT;
            end
            S_RD_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = cnt_last ? WB_DATA_WIDTH'(CMD_READ_NAK)
                                   : WB_DATA_WIDTH'(CMD_READ_ACK);
                if (acc_done) state_d = S_WAIT;
            end
            S_RD_DPR: begin
                acc_go  = !acc_busy;
                acc_we  = 1'b0;
                acc_adr = WB_ADDR_WIDTH'(REG_DPR);
                if (acc_done) state_d = cnt_last ? S_STOP_CMD : S_RD_CMD;
            end
            S_STOP_CMD: begin
                acc_go  = !acc_busy;
                acc_dat = WB_DATA_WIDTH'(CMD_STOP);
                if (acc_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (irq_i) state_d = S_IRQ_READ;
            end
            S_IRQ_READ: begin
                acc_go = !acc_busy;
                acc_we = 1'b0;
                if (acc_done) begin
                    if (acc_rdata[CMDR_DON]) begin
                        state_d = after_don;
                    end else if (acc_rdata[CMDR_NAK]) begin
                        // A NAK reported against STOP itself cannot be
                        // recovered by another STOP
                        state_d = (cmd_q == S_STOP_CMD) ? S_DONE : S_STOP_CMD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Request latch, byte counter, read data and status tracking
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            wr_byte_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            status_q   <= STAT_OK;
            cmd_q      <= S_INIT;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        bus_q    <= req_bus_i;
                        addr_q   <= req_addr_i;
                        rw_q     <= req_rw_i;
                        cnt_q    <= req_len_i;
                        status_q <= STAT_OK;
                    end
                end
                S_WR_FETCH: begin
                    if (wr_valid_i) wr_byte_q <= wr_data_i;
                end
                S_RD_DPR: begin
                    if (acc_done) begin
                        rd_data_q  <= acc_rdata[7:0];
                        rd_valid_q <= 1'b1;
                        cnt_q      <= cnt_q - LEN_WIDTH'(1);
                    end
                end
                S_IRQ_READ: begin
                    if (acc_done) begin
                        if (acc_rdata[CMDR_DON]) begin
                            if (cmd_q == S_WR_CMD) cnt_q <= cnt_q - LEN_WIDTH'(1);
                        end else if (acc_rdata[CMDR_NAK]) begin
                            status_q <= STAT_NAK;
                        end else if (acc_rdata[CMDR_AL]) begin
                            status_q <= STAT_AL;
                        end else begin
                            status_q <= STAT_ERR;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (state_d == S_WAIT && state_q != S_WAIT) cmd_q <= state_q;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR_FETCH) && wr_valid_i;
    assign done_o      = (state_q == S_DONE);
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign status_o    = status_q;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench for i2cmb_wb_sequencer with a behavioural iicmb_m_wb model
// and one I2C slave at address 0x22.
module tb_i2cmb_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [3:0] req_bus_i = '0;
    logic [6:0] req_addr_i = '0;
    logic       req_rw_i = 1'b0;
    logic [7:0] req_len_i = '0;
    logic [7:0] wr_data_i = '0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       done_o;
    logic [1:0] status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i2cmb_wb_sequencer dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_bus_i   (req_bus_i),
        .req_addr_i  (req_addr_i),
        .req_rw_i    (req_rw_i),
        .req_len_i   (req_len_i),
        .wr_data_i   (wr_data_i),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .done_o      (done_o),
        .status_o    (status_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .irq_i       (irq_i)
    );

    // ---------------- controller + slave model ----------------
    logic [9:0] wlog[$];       // {adr, dat} of every Wishbone write
    logic [7:0] slave_rx[$];   // bytes the slave received
    logic [7:0] slave_tx[8];   // bytes the slave returns on reads
    logic [7:0] csr = '0, dpr_w = '0, dpr_r = '0, cmdr_stat = '0;
    int         irq_dly = 0;
    int         rd_idx = 0;
    bit         addr_phase = 0;

    always @(negedge clk) begin
        if (irq_dly > 0) begin
            irq_dly--;
            if (irq_dly == 0) irq_i = 1'b1;
        end
        if (ack_i) begin
            ack_i = 1'b0;
        end else if (cyc_o && stb_o) begin
            ack_i = 1'b1;
            if (we_o) begin
                wlog.push_back({adr_o, dat_o});
                case (adr_o)
                    2'd0: begin
                        csr = dat_o; irq_i = 1'b0; irq_dly = 0; addr_phase = 0;
                    end
                    2'd1: dpr_w = dat_o;
                    2'd2: begin
                        cmdr_stat = 8'h80;
                        irq_dly = 4;
                        case (dat_o)
                            8'h04: begin addr_phase = 1; rd_idx = 0; end
                            8'h03: begin
                                if (addr_phase) begin
                                    addr_phase = 0;
                                    if (dpr_w[7:1] != 7'h22) cmdr_stat = 8'h40;
                                end else begin
                                    slave_rx.push_back(dpr_w);
                                end
                            end
                            8'h01, 8'h02: begin
                                dpr_r = slave_tx[rd_idx];
                                rd_idx++;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end else begin
                case (adr_o)
                    2'd0: dat_i = csr;
                    2'd1: dat_i = dpr_r;
                    2'd2: begin dat_i = cmdr_stat; irq_i = 1'b0; end
                    default: dat_i = 8'h00;
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [9:0] exp_w[$];

    task automatic check_log(input string tag, input int base);
        check({tag, "_wlen"}, wlog.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size() && base + i < wlog.size(); i++)
            check(tag, 32'(wlog[base + i]), 32'(exp_w[i]));
    endtask

    logic [7:0] wbytes[8];
    logic [7:0] rbytes[8];

    task automatic run_txn(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                           input logic [7:0] len, input int stall_at,
                           output int n_rd, output logic [1:0] stat, output int stall_cyc);
        int  idx, stall_left;
        bit  adv, seen_done;
        @(negedge clk);
        check("req_ready_before_req", 32'(req_ready_o), 1);
        req_valid_i = 1'b1; req_bus_i = bus; req_addr_i = addr; req_rw_i = rw; req_len_i = len;
        idx = 0; adv = 0; stall_left = 0; n_rd = 0; seen_done = 0; stall_cyc = 0; stat = 2'bxx;
        wr_data_i  = wbytes[0];
        wr_valid_i = !rw && len != 0;
        @(negedge clk);
        req_valid_i = 1'b0;
        for (int b = 0; b < 3000 && !seen_done; b++) begin
            @(negedge clk);
            if (done_o) begin seen_done = 1; stat = status_o; end
            if (rd_valid_o && n_rd < 8) begin rbytes[n_rd] = rd_data_o; n_rd++; end
            if (adv) begin
                idx++;
                if (idx == stall_at) stall_left = 50;
            end
            if (stall_left > 0) begin
                if (stall_left <= 20 && cyc_o) stall_cyc++;
                stall_left--;
            end
            wr_data_i  = wbytes[idx % 8];
            wr_valid_i = !rw && idx < int'(len) && stall_left == 0;
            #1;
            adv = wr_ready_o;
        end
        wr_valid_i = 1'b0;
        check("done_seen", 32'(seen_done), 1);
    endtask

    // ---------------- directed sequence ----------------
    int         base, rx_base, n_rd, stall_cyc;
    logic [1:0] stat;
    bit         seen;

    initial begin
        for (int i = 0; i < 8; i++) begin wbytes[i] = '0; slave_tx[i] = '0; rbytes[i] = '0; end

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({req_ready_o, wr_ready_o, rd_valid_o, done_o, status_o, cyc_o, stb_o,
                   we_o, adr_o, dat_o, rd_data_o}), 0);
        rst_n_i = 1'b1;

        // Init write
        seen = 0;
        for (int b = 0; b < 20 && !seen; b++) begin
            @(negedge clk);
            if (cyc_o) seen = 1;
        end
        check("init_cyc_seen", 32'(seen), 1);
        check("init_we", 32'(we_o), 1);
        check("init_adr", 32'(adr_o), 0);
        check("init_dat", 32'(dat_o), 32'hC0);
        @(posedge clk);
        @(negedge clk);
        check("init_ready_after_ack", 32'(req_ready_o), 1);

        // Write bus 0, addr 0x22, len 3
        base = wlog.size(); rx_base = slave_rx.size();
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        run_txn(4'd0, 7'h22, 1'b0, 8'd3, -1, n_rd, stat, stall_cyc);
        check("wr3_status", 32'(stat), 0);
        exp_w = '{{2'd1, 8'h00}, {2'd2, 8'h06}, {2'd2, 8'h04}, {2'd1, 8'h44}, {2'd2, 8'h03},
                  {2'd1, 8'h11}, {2'd2, 8'h03}, {2'd1, 8'h22}, {2'd2, 8'h03},
                  {2'd1, 8'h33}, {2'd2, 8'h03}, {2'd2, 8'h05}};
        check_log("wr3_log", base);
        check("wr3_rx_count", slave_rx.size() - rx_base, 3);
        if (slave_rx.size() - rx_base == 3)
            check("wr3_rx_bytes", 32'({slave_rx[rx_base], slave_rx[rx_base+1], slave_rx[rx_base+2]}),
                  32'h112233);

        // Read addr 0x22, len 2
        base = wlog.size();
        slave_tx[0] = 8'hA5; slave_tx[1] = 8'h5A;
        run_txn(4'd0, 7'h22, 1'b1, 8'd2, -1, n_rd, stat, stall_cyc);
        check("rd2_status", 32'(stat), 0);
        check("rd2_count", n_rd, 2);
        check("rd2_byte0", 32'(rbytes[0]), 32'hA5);
        check("rd2_byte1", 32'(rbytes[1]), 32'h5A);
        exp_w = '{{2'd1, 8'h00}, {2'd2, 8'h06}, {2'd2, 8'h04}, {2'd1, 8'h45}, {2'd2, 8'h03},
                  {2'd2, 8'h01}, {2'd2, 8'h02}, {2'd2, 8'h05}};
        check_log("rd2_log", base);

        // Probe absent addr 0x10, len 0
        base = wlog.size(); rx_base = slave_rx.size();
        run_txn(4'd0, 7'h10, 1'b0, 8'd0, -1, n_rd, stat, stall_cyc);
        check("probe_status", 32'(stat), 1);
        exp_w = '{{2'd1, 8'h00}, {2'd2, 8'h06}, {2'd2, 8'h04}, {2'd1, 8'h20}, {2'd2, 8'h03},
                  {2'd2, 8'h05}};
        check_log("probe_log", base);
        check("probe_rx_none", slave_rx.size() - rx_base, 0);

        // Write len 4 on bus 2 with a 50-cycle upstream stall before byte 2
        base = wlog.size(); rx_base = slave_rx.size();
        wbytes[0] = 8'h01; wbytes[1] = 8'h02; wbytes[2] = 8'h03; wbytes[3] = 8'h04;
        run_txn(4'd2, 7'h22, 1'b0, 8'd4, 1, n_rd, stat, stall_cyc);
        check("stall_status", 32'(stat), 0);
        check("stall_no_bus_activity", stall_cyc, 0);
        check("stall_bus_dpr", 32'(wlog[base]), 32'({2'd1, 8'h02}));
        check("stall_rx_count", slave_rx.size() - rx_base, 4);
        if (slave_rx.size() - rx_base == 4)
            check("stall_rx_bytes", {slave_rx[rx_base], slave_rx[rx_base+1],
                                     slave_rx[rx_base+2], slave_rx[rx_base+3]}, 32'h01020304);

        // Reset during byte 2 of a read
        slave_tx[0] = 8'hC1; slave_tx[1] = 8'hC2; slave_tx[2] = 8'hC3;
        @(negedge clk);
        req_valid_i = 1'b1; req_bus_i = 4'd0; req_addr_i = 7'h22; req_rw_i = 1'b1; req_len_i = 8'd3;
        @(negedge clk);
        req_valid_i = 1'b0;
        seen = 0;
        for (int b = 0; b < 500 && !seen; b++) begin
            @(negedge clk);
            if (rd_valid_o) begin seen = 1; rbytes[0] = rd_data_o; end
        end
        check("rst_first_byte_seen", 32'(seen), 1);
        check("rst_first_byte", 32'(rbytes[0]), 32'hC1);
        seen = 0;
        for (int b = 0; b < 50 && !seen; b++) begin
            @(negedge clk);
            if (cyc_o) seen = 1;
        end
        check("rst_byte2_access_seen", 32'(seen), 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rst_cyc_stb_drop", 32'({cyc_o, stb_o}), 0);
        check("rst_ready_low", 32'(req_ready_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        base = wlog.size();
        seen = 0;
        for (int b = 0; b < 20 && !seen; b++) begin
            @(negedge clk);
            if (cyc_o) seen = 1;
        end
        check("reinit_cyc_seen", 32'(seen), 1);
        check("reinit_access", 32'({we_o, adr_o, dat_o}), 32'({1'b1, 2'd0, 8'hC0}));
        seen = 0;
        for (int b = 0; b < 20 && !seen; b++) begin
            @(negedge clk);
            if (req_ready_o) seen = 1;
        end
        check("reinit_ready", 32'(seen), 1);
        check("reinit_csr_logged", 32'(wlog[base]), 32'({2'd0, 8'hC0}));
        rx_base = slave_rx.size();
        wbytes[0] = 8'h7E;
        run_txn(4'd0, 7'h22, 1'b0, 8'd1, -1, n_rd, stat, stall_cyc);
        check("post_rst_status", 32'(stat), 0);
        check("post_rst_rx_count", slave_rx.size() - rx_base, 1);
        if (slave_rx.size() - rx_base == 1)
            check("post_rst_rx_byte", 32'(slave_rx[rx_base]), 32'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2cmb_wb_sequencer.md
Name: i2cmb_wb_sequencer

Overview:
- Wishbone master command sequencer that sits directly upstream of the iicmb_m_wb controller.
- Accepts one high-level I2C transaction request: bus, 7-bit address, direction, byte count, plus a byte stream.
- Converts it into the controller's CSR/DPR/CMDR register writes and reads.
- Waits on irq_i for each command completion, returns read bytes and a completion status.

Parameters:
- WB_ADDR_WIDTH, 2, Wishbone address width (CSR=0, DPR=1, CMDR=2, FSMR=3)
- WB_DATA_WIDTH, 8, Wishbone data width
- I2C_ADDR_WIDTH, 7, I2C slave address width
- LEN_WIDTH, 8, byte-count width

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  transaction request valid
- req_ready_o  out  1  sequencer idle and able to accept a request
- req_bus_i  in  4  target I2C bus index
- req_addr_i  in  I2C_ADDR_WIDTH  slave address
- req_rw_i  in  1  1=read, 0=write
- req_len_i  in  LEN_WIDTH  number of data bytes; 0 = address probe
- wr_data_i  in  8  write byte
- wr_valid_i  in  1  write byte valid
- wr_ready_o  out  1  write byte consumed this cycle
- rd_data_o  out  8  read byte
- rd_valid_o  out  1  one-cycle pulse, rd_data_o valid
- done_o  out  1  one-cycle pulse, transaction finished
- status_o  out  2  00 OK, 01 NAK, 10 arbitration lost, 11 ERR; held until next request
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register address
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  controller interrupt

Behaviour:
- Reset: all outputs 0; req_ready_o=0 until the init write completes; state=INIT.
- Wishbone access primitive:
  - Assert cyc/stb with we/adr/dat; hold all of them until ack_i=1.
  - Sample dat_i on the ack cycle.
  - Deassert for at least 1 cycle before the next access.
  - No timeout.
- INIT: write CSR=0xC0 (enable and IRQ enable) once after reset, then go to IDLE with req_ready_o=1.
- IDLE:
  - On req_valid_i && req_ready_o, latch bus/addr/rw/len and drop req_ready_o.
  - Clear status_o to 00.
- Command sequence:
  - SETBUS: DPR=bus, CMDR=0x06, WAIT.
  - START: CMDR=0x04, WAIT.
  - ADDR: DPR={addr,rw}, CMDR=0x03, WAIT.
  - DATA loop, repeated len times:
    - Write: stall with wr_ready_o=0 until wr_valid_i; wr_ready_o pulses 1 cycle on capture; then DPR=byte, CMDR=0x03, WAIT.
    - Read: CMDR=0x01 (ACK), or 0x02 (NAK) for the last byte; WAIT; read DPR; pulse rd_valid_o.
  - STOP: CMDR=0x05, WAIT.
  - DONE: pulse done_o, return to IDLE.
- WAIT:
  - Idle until irq_i=1, then read CMDR (this clears irq).
  - Decode priority: bit7 DON→continue; bit6 NAK→status 01, go to STOP; bit5 AL→status 10, go to DONE with no STOP; bit4 ERR→status 11, go to DONE.
- NAK on a write data byte: abort the remaining bytes, issue STOP.
- Byte counter is LEN_WIDTH wide and down-counting. len=0 skips the DATA loop.
- Each data byte is fetched from the upstream stream only after the preceding WAIT completes. Sequencer holds at most 1 byte.
- irq_i already high on WAIT entry: proceed immediately.
- req_valid_i while busy is ignored, with no latching.
- Asynchronous reset mid-transaction: immediately returns to INIT and drops cyc/stb. The controller is re-enabled by the init write.

Decomposition:
- Package i2cmb_seq_pkg:
  - Register address constants CSR/DPR/CMDR/FSMR.
  - Command opcodes: SET_BUS=6, START=4, STOP=5, WRITE=3, READ_ACK=1, READ_NAK=2.
  - Status enum.
  - FSM state enum.
- Sub-module i2cmb_wb_access: single-access Wishbone master handshake (go/we/adr/dat in; busy/done/rdata out), reused by every state.

Test Plan:
- Init → first bus activity after reset release is a write to adr 0 with data 0xC0; req_ready_o rises within 1 cycle after its ack.
- Write bus 0, addr 0x22, len 3, data 0x11/0x22/0x33 →
  - Wishbone log: DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x03, (DPR 0x11/0x22/0x33 each followed by CMDR 0x03), CMDR 0x05.
  - I2C slave model receives 11 22 33.
  - done_o pulses with status 00.
- Read addr 0x22, len 2, slave returns 0xA5/0x5A →
  - CMDR 0x01 then 0x02.
  - rd_valid_o pulses twice with A5 then 5A; status 00.
- Probe addr 0x10 (absent), len 0 → NAK on address; CMDR 0x05 issued; done_o with status 01; no data commands.
- Write len 4 with wr_valid_i held low 50 cycles before byte 2 → no Wishbone activity during the stall; all 4 bytes delivered in order.
- Assert rst_n_i low during byte 2 of a read →
  - cyc_o/stb_o drop asynchronously.
  - After release, the CSR=0xC0 write is reissued.
  - A new request completes with status 00.
